// File: rtl/friscv_dispatch_pkg.sv
// Shared types and helpers for the issue stage: FSM states, register count and
// the scoreboard hazard test.
package friscv_dispatch_pkg;

  localparam int REG_NB     = 32;
  localparam int INST_BUS_W = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // x0 never hazards because pending[0] is held at zero by the scoreboard.
  function automatic logic hazard(input logic [REG_NB-1:0] pending,
                                  input logic [4:0]        rs1,
                                  input logic [4:0]        rs2,
                                  input logic [4:0]        rd);
    return pending[rs1] | pending[rs2] | pending[rd];
  endfunction

endpackage

// File: rtl/friscv_scoreboard.sv
// Pending-destination scoreboard: one set port, NB_CLR retire ports.
// When a register is set and cleared in the same cycle, the set wins.
module friscv_scoreboard
  import friscv_dispatch_pkg::*;
#(
  parameter int NB_CLR = 2
)(
  input  logic                aclk,
  input  logic                areset,
  input  logic                set_en,
  input  logic [4:0]          set_addr,
  input  logic [NB_CLR-1:0]   clr_en,
  input  logic [5*NB_CLR-1:0] clr_addr,
  output logic [REG_NB-1:0]   pending
);

  logic [REG_NB-1:0] pending_q, pending_d;
  logic [REG_NB-1:0] set_mask, clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_addr] = 1'b1;
    for (int i = 0; i < NB_CLR; i++) begin
      if (clr_en[i]) clr_mask[clr_addr[5*i +: 5]] = 1'b1;
    end
    pending_d    = (pending_q & ~clr_mask) | set_mask;
    pending_d[0] = 1'b0;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign pending = pending_q;

endmodule

// File: rtl/friscv_dispatcher.sv
// Issue stage for NB_UNIT execution units: steers each instruction to one unit,
// stalls on RAW/WAW hazards and drains every unit on a fence.
module friscv_dispatcher
  import friscv_dispatch_pkg::*;
#(
  parameter  int XLEN    = 32,
  parameter  int NB_UNIT = 2,
  parameter  int INST_W  = INST_BUS_W,
  parameter  int CNT_W   = 32,
  localparam int UNIT_W  = (NB_UNIT > 1) ? $clog2(NB_UNIT) : 1
)(
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 inst_valid,
  output logic                 inst_ready,
  input  logic [UNIT_W-1:0]    inst_unit,
  input  logic [4:0]           inst_rs1,
  input  logic [4:0]           inst_rs2,
  input  logic [4:0]           inst_rd,
  input  logic                 inst_fence,
  input  logic [INST_W-1:0]    inst_bus,
  output logic [NB_UNIT-1:0]   unit_en,
  output logic [INST_W-1:0]    unit_instbus,
  input  logic [NB_UNIT-1:0]   unit_ready,
  input  logic [NB_UNIT-1:0]   unit_empty,
  input  logic [NB_UNIT-1:0]   unit_rd_wr,
  input  logic [5*NB_UNIT-1:0] unit_rd_addr,
  output logic                 proc_empty,
  output logic [CNT_W-1:0]     stall_cnt
);

  if (NB_UNIT < 1 || NB_UNIT > 8 || XLEN < 1) begin : g_param_check
    $error("friscv_dispatcher: NB_UNIT must be within 1..8");
  end

  state_t            state_q, state_d;
  logic [REG_NB-1:0] pending;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              sel_ready, hazard_hit, all_empty, issue;

  assign hazard_hit = hazard(pending, inst_rs1, inst_rs2, inst_rd);
  assign all_empty  = &unit_empty;

  // An out-of-range unit index selects nothing, so it is never accepted.
  always_comb begin
    sel_ready = 1'b0;
    for (int i = 0; i < NB_UNIT; i++) begin
      if (int'(inst_unit) == i) sel_ready = unit_ready[i];
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (inst_valid && inst_fence)       state_d = DRAIN;
      DRAIN: if (all_empty && (pending == '0))   state_d = IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    inst_ready = 1'b0;
    issue      = 1'b0;
    unit_en    = '0;
    if (!areset && (state_q == IDLE)) begin
      if (inst_fence) begin
        inst_ready = 1'b1;
      end else begin
        inst_ready = sel_ready && !hazard_hit;
        issue      = inst_valid && inst_ready;
      end
    end
    for (int i = 0; i < NB_UNIT; i++) begin
      unit_en[i] = issue && (int'(inst_unit) == i);
    end
  end

  friscv_scoreboard #(
    .NB_CLR (NB_UNIT)
  ) u_scoreboard (
    .aclk     (aclk),
    .areset   (areset),
    .set_en   (issue && (inst_rd != 5'd0)),
    .set_addr (inst_rd),
    .clr_en   (unit_rd_wr),
    .clr_addr (unit_rd_addr),
    .pending  (pending)
  );

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (inst_valid && !inst_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt    = stall_cnt_q;
  assign unit_instbus = inst_bus;
  assign proc_empty   = (state_q == IDLE) && all_empty && (pending == '0);

endmodule

// File: tb/tb_friscv_dispatcher.sv
// Bench for friscv_dispatcher: directed scenarios on an NB_UNIT=2 instance plus
// randomized traffic on NB_UNIT=1,4,8 against a register-level reference model.
module tb_friscv_dispatcher;

  localparam int NI = 4;

  function automatic int nb_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      2:       return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int cw_of(input int k);
    return (k == 1) ? 2 : 32;
  endfunction

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic                 areset;
  logic [NI-1:0]        s_valid, s_fence;
  logic [NI-1:0][2:0]   s_unit;
  logic [NI-1:0][4:0]   s_rs1, s_rs2, s_rd;
  logic [NI-1:0][31:0]  s_bus;
  logic [NI-1:0][7:0]   s_uready, s_uempty, s_uwr;
  logic [NI-1:0][39:0]  s_uaddr;
  logic [NI-1:0]        o_ready, o_pempty;
  logic [NI-1:0][7:0]   o_en;
  logic [NI-1:0][31:0]  o_ibus, o_stall;

  int checks = 0;
  int errors = 0;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int NB = nb_of(k);
    localparam int UW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW = cw_of(k);
    logic [NB-1:0] en;
    logic [CW-1:0] st;
    logic          rdy, pe;
    logic [31:0]   ib;

    friscv_dispatcher #(
      .XLEN(32), .NB_UNIT(NB), .INST_W(32), .CNT_W(CW)
    ) u_dut (
      .aclk         (aclk),
      .areset       (areset),
      .inst_valid   (s_valid[k]),
      .inst_ready   (rdy),
      .inst_unit    (s_unit[k][UW-1:0]),
      .inst_rs1     (s_rs1[k]),
      .inst_rs2     (s_rs2[k]),
      .inst_rd      (s_rd[k]),
      .inst_fence   (s_fence[k]),
      .inst_bus     (s_bus[k]),
      .unit_en      (en),
      .unit_instbus (ib),
      .unit_ready   (s_uready[k][NB-1:0]),
      .unit_empty   (s_uempty[k][NB-1:0]),
      .unit_rd_wr   (s_uwr[k][NB-1:0]),
      .unit_rd_addr (s_uaddr[k][5*NB-1:0]),
      .proc_empty   (pe),
      .stall_cnt    (st)
    );

    assign o_ready[k]  = rdy;
    assign o_pempty[k] = pe;
    assign o_en[k]     = 8'(en);
    assign o_stall[k]  = 32'(st);
    assign o_ibus[k]   = ib;
  end

  task automatic idle_all();
    s_valid  = '0;
    s_fence  = '0;
    s_unit   = '0;
    s_rs1    = '0;
    s_rs2    = '0;
    s_rd     = '0;
    s_bus    = '0;
    s_uready = '1;
    s_uempty = '1;
    s_uwr    = '0;
    s_uaddr  = '0;
  endtask

  task automatic drive(input int k, input bit v, input bit f, input int u,
                       input int r1, input int r2, input int rd);
    s_valid[k] = v;
    s_fence[k] = f;
    s_unit[k]  = 3'(u);
    s_rs1[k]   = 5'(r1);
    s_rs2[k]   = 5'(r2);
    s_rd[k]    = 5'(rd);
    s_bus[k]   = $urandom;
  endtask

  task automatic tick();
    @(negedge aclk);
  endtask

  task automatic test_reset();
    idle_all();
    areset = 1'b1;
    drive(0, 1, 0, 0, 0, 0, 0);
    #1;
    checks++; if (o_ready[0] !== 1'b0) begin errors++; $display("FAIL reset_ready got %b expected 0", o_ready[0]); end
    checks++; if (o_en[0] !== 8'h00) begin errors++; $display("FAIL reset_en got %h expected 00", o_en[0]); end
    tick();
    areset     = 1'b0;
    s_valid[0] = 1'b0;
    #1;
    checks++; if (o_stall[0] !== 32'd0) begin errors++; $display("FAIL reset_stall got %0d expected 0", o_stall[0]); end
    checks++; if (o_pempty[0] !== 1'b1) begin errors++; $display("FAIL reset_pempty got %b expected 1", o_pempty[0]); end
    tick();
  endtask

  task automatic test_raw();
    drive(0, 1, 0, 0, 0, 0, 5);
    #1;
    checks++; if (o_en[0] !== 8'h01) begin errors++; $display("FAIL raw_first_en got %h expected 01", o_en[0]); end
    checks++; if (o_ibus[0] !== s_bus[0]) begin errors++; $display("FAIL raw_instbus got %h expected %h", o_ibus[0], s_bus[0]); end
    tick();
    drive(0, 1, 0, 1, 5, 0, 0);
    s_uempty[0] = 8'hFE;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (o_ready[0] !== 1'b0 || o_en[0] !== 8'h00) begin errors++; $display("FAIL raw_stall ready %b en %h expected 0 00", o_ready[0], o_en[0]); end
      tick();
    end
    s_uwr[0]        = 8'h01;
    s_uaddr[0][4:0] = 5'd5;
    #1;
    checks++; if (o_ready[0] !== 1'b0) begin errors++; $display("FAIL raw_no_bypass got %b expected 0", o_ready[0]); end
    tick();
    s_uwr[0]    = 8'h00;
    s_uempty[0] = 8'hFF;
    #1;
    checks++; if (o_en[0] !== 8'h02) begin errors++; $display("FAIL raw_issue_after_retire got %h expected 02", o_en[0]); end
    checks++; if (o_stall[0] !== 32'd4) begin errors++; $display("FAIL raw_stall_cnt got %0d expected 4", o_stall[0]); end
    tick();
    s_valid[0] = 1'b0;
  endtask

  task automatic test_waw();
    drive(0, 1, 0, 0, 0, 0, 7);
    #1;
    checks++; if (o_en[0] !== 8'h01) begin errors++; $display("FAIL waw_first_en got %h expected 01", o_en[0]); end
    tick();
    drive(0, 1, 0, 1, 0, 0, 7);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (o_ready[0] !== 1'b0 || o_en[0] !== 8'h00) begin errors++; $display("FAIL waw_stall ready %b en %h expected 0 00", o_ready[0], o_en[0]); end
      tick();
    end
    s_uwr[0]        = 8'h01;
    s_uaddr[0][4:0] = 5'd7;
    #1;
    checks++; if (o_ready[0] !== 1'b0) begin errors++; $display("FAIL waw_retire_cycle got %b expected 0", o_ready[0]); end
    tick();
    s_uwr[0] = 8'h00;
    #1;
    checks++; if (o_en[0] !== 8'h02) begin errors++; $display("FAIL waw_issue got %h expected 02", o_en[0]); end
    tick();
    s_valid[0]      = 1'b0;
    s_uwr[0]        = 8'h02;
    s_uaddr[0][9:5] = 5'd7;
    #1;
    checks++; if (o_pempty[0] !== 1'b0) begin errors++; $display("FAIL waw_pempty_busy got %b expected 0", o_pempty[0]); end
    tick();
    s_uwr[0] = 8'h00;
    #1;
    checks++; if (o_pempty[0] !== 1'b1) begin errors++; $display("FAIL waw_pempty_idle got %b expected 1", o_pempty[0]); end
    tick();
  endtask

  task automatic test_same_cycle();
    drive(0, 1, 0, 0, 0, 0, 3);
    s_uwr[0]        = 8'h02;
    s_uaddr[0][9:5] = 5'd3;
    #1;
    checks++; if (o_en[0] !== 8'h01) begin errors++; $display("FAIL same_issue got %h expected 01", o_en[0]); end
    tick();
    s_uwr[0] = 8'h00;
    drive(0, 1, 0, 1, 3, 0, 0);
    #1;
    checks++; if (o_ready[0] !== 1'b0) begin errors++; $display("FAIL same_set_wins got %b expected 0", o_ready[0]); end
    tick();
    drive(0, 1, 0, 1, 0, 0, 10);
    #1;
    checks++; if (o_en[0] !== 8'h02) begin errors++; $display("FAIL same_issue_x10 got %h expected 02", o_en[0]); end
    tick();
    s_valid[0]      = 1'b0;
    s_uwr[0]        = 8'h03;
    s_uaddr[0][4:0] = 5'd3;
    s_uaddr[0][9:5] = 5'd10;
    #1;
    checks++; if (o_pempty[0] !== 1'b0) begin errors++; $display("FAIL same_pempty_busy got %b expected 0", o_pempty[0]); end
    tick();
    s_uwr[0] = 8'h00;
    drive(0, 1, 0, 0, 3, 10, 0);
    #1;
    checks++; if (o_en[0] !== 8'h01) begin errors++; $display("FAIL same_dual_retire got %h expected 01", o_en[0]); end
    tick();
    s_valid[0] = 1'b0;
  endtask

  task automatic test_fence();
    s_uempty[0] = 8'hFD;
    drive(0, 1, 1, 1, 0, 0, 0);
    #1;
    checks++; if (o_ready[0] !== 1'b1) begin errors++; $display("FAIL fence_accept got %b expected 1", o_ready[0]); end
    checks++; if (o_en[0] !== 8'h00) begin errors++; $display("FAIL fence_not_forwarded got %h expected 00", o_en[0]); end
    tick();
    drive(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (o_ready[0] !== 1'b0 || o_en[0] !== 8'h00 || o_pempty[0] !== 1'b0) begin errors++; $display("FAIL fence_drain ready %b en %h pempty %b expected 0 00 0", o_ready[0], o_en[0], o_pempty[0]); end
      tick();
    end
    s_uempty[0] = 8'hFF;
    #1;
    checks++; if (o_ready[0] !== 1'b0) begin errors++; $display("FAIL fence_exit_cycle got %b expected 0", o_ready[0]); end
    tick();
    #1;
    checks++; if (o_en[0] !== 8'h01) begin errors++; $display("FAIL fence_after_exit got %h expected 01", o_en[0]); end
    tick();
    drive(0, 1, 1, 0, 0, 0, 0);
    #1;
    checks++; if (o_ready[0] !== 1'b1) begin errors++; $display("FAIL fence2_accept got %b expected 1", o_ready[0]); end
    tick();
    drive(0, 1, 0, 0, 0, 0, 0);
    #1;
    checks++; if (o_ready[0] !== 1'b0) begin errors++; $display("FAIL fence2_min_drain got %b expected 0", o_ready[0]); end
    tick();
    #1;
    checks++; if (o_en[0] !== 8'h01) begin errors++; $display("FAIL fence2_resume got %h expected 01", o_en[0]); end
    tick();
    s_valid[0] = 1'b0;
  endtask

  task automatic test_reset_drain();
    for (int r = 4; r < 8; r++) begin
      drive(0, 1, 0, 0, 0, 0, r);
      #1;
      checks++; if (o_en[0] !== 8'h01) begin errors++; $display("FAIL rdrain_fill_x%0d got %h expected 01", r, o_en[0]); end
      tick();
    end
    s_uempty[0] = 8'hFE;
    drive(0, 1, 1, 0, 0, 0, 0);
    #1;
    checks++; if (o_ready[0] !== 1'b1) begin errors++; $display("FAIL rdrain_fence got %b expected 1", o_ready[0]); end
    tick();
    drive(0, 1, 0, 1, 4, 0, 0);
    #1;
    checks++; if (o_ready[0] !== 1'b0 || o_pempty[0] !== 1'b0) begin errors++; $display("FAIL rdrain_busy ready %b pempty %b expected 0 0", o_ready[0], o_pempty[0]); end
    #2;
    areset = 1'b1;
    #1;
    checks++; if (o_ready[0] !== 1'b0 || o_en[0] !== 8'h00) begin errors++; $display("FAIL rdrain_in_reset ready %b en %h expected 0 00", o_ready[0], o_en[0]); end
    checks++; if (o_stall[0] !== 32'd0) begin errors++; $display("FAIL rdrain_stall_async got %0d expected 0", o_stall[0]); end
    tick();
    areset      = 1'b0;
    s_uempty[0] = 8'hFF;
    #1;
    checks++; if (o_pempty[0] !== 1'b1 && s_valid[0] === 1'b0) begin errors++; $display("FAIL rdrain_pempty got %b expected 1", o_pempty[0]); end
    checks++; if (o_en[0] !== 8'h02) begin errors++; $display("FAIL rdrain_idle_issue got %h expected 02", o_en[0]); end
    checks++; if (o_stall[0] !== 32'd0) begin errors++; $display("FAIL rdrain_stall got %0d expected 0", o_stall[0]); end
    tick();
    s_valid[0] = 1'b0;
    #1;
    checks++; if (o_pempty[0] !== 1'b1) begin errors++; $display("FAIL rdrain_pempty_after got %b expected 1", o_pempty[0]); end
    tick();
  endtask

  task automatic test_out_of_range();
    drive(1, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (o_ready[1] !== 1'b0 || o_en[1] !== 8'h00) begin errors++; $display("FAIL oor_reject ready %b en %h expected 0 00", o_ready[1], o_en[1]); end
      tick();
    end
    #1;
    checks++; if (o_stall[1] !== 32'd3) begin errors++; $display("FAIL oor_stall_saturate got %0d expected 3", o_stall[1]); end
    s_unit[1] = 3'd0;
    #1;
    checks++; if (o_en[1] !== 8'h01) begin errors++; $display("FAIL oor_valid_unit got %h expected 01", o_en[1]); end
    tick();
    s_valid[1] = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] m_pend  [NI];
    int          m_owner [NI][32];
    bit          m_drain [NI];
    longint      m_stall [NI];
    logic [31:0] clr_mask;
    int          nb, u, r, st, r1, r2, rd;
    bit          v, f, hz, exp_ready, owned, found;
    logic [7:0]  exp_en;
    longint      sat;

    idle_all();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    for (int k = 0; k < NI; k++) begin
      m_pend[k]  = '0;
      m_drain[k] = 1'b0;
      m_stall[k] = 0;
      for (int j = 0; j < 32; j++) m_owner[k][j] = -1;
    end

    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < NI; k++) begin
        nb = nb_of(k);
        drive(k, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
              $urandom_range(0, nb - 1), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 7));
        s_uready[k] = 8'($urandom | $urandom);
        s_uwr[k]    = '0;
        s_uaddr[k]  = '0;
        s_uempty[k] = '1;
        for (int uu = 0; uu < nb; uu++) begin
          owned = 1'b0;
          found = 1'b0;
          st    = $urandom_range(1, 31);
          for (int j = 0; j < 31; j++) begin
            r = 1 + ((st - 1 + j) % 31);
            if (m_pend[k][r] && m_owner[k][r] == uu) begin
              owned = 1'b1;
              if (!found && $urandom_range(0, 1) == 1) begin
                found = 1'b1;
                s_uwr[k][uu]         = 1'b1;
                s_uaddr[k][5*uu +: 5] = 5'(r);
              end
            end
          end
          s_uempty[k][uu] = !owned;
          if (!owned && $urandom_range(0, 3) == 0) begin
            r = $urandom_range(1, 31);
            if (!m_pend[k][r]) begin
              s_uwr[k][uu]          = 1'b1;
              s_uaddr[k][5*uu +: 5] = 5'(r);
            end
          end
        end
      end
      #1;
      for (int k = 0; k < NI; k++) begin
        v  = s_valid[k];
        f  = s_fence[k];
        u  = int'(s_unit[k]);
        r1 = int'(s_rs1[k]);
        r2 = int'(s_rs2[k]);
        rd = int'(s_rd[k]);
        hz = m_pend[k][r1] | m_pend[k][r2] | m_pend[k][rd];
        exp_ready = !m_drain[k] && (f || (s_uready[k][u] && !hz));
        exp_en    = (v && exp_ready && !f) ? 8'(1 << u) : 8'h00;
        if (v) begin
          checks++; if (o_ready[k] !== exp_ready) begin errors++; $display("FAIL rnd_ready k=%0d cyc=%0d got %b expected %b", k, cyc, o_ready[k], exp_ready); end
        end
        checks++; if (o_en[k] !== exp_en) begin errors++; $display("FAIL rnd_en k=%0d cyc=%0d got %h expected %h", k, cyc, o_en[k], exp_en); end
        checks++; if (!$onehot0(o_en[k])) begin errors++; $display("FAIL rnd_onehot k=%0d cyc=%0d got %h expected one-hot or zero", k, cyc, o_en[k]); end
        checks++; if (o_en[k] != 8'h00 && hz) begin errors++; $display("FAIL rnd_hazard_issued k=%0d cyc=%0d en %h pending %h", k, cyc, o_en[k], m_pend[k]); end
        if (v && !f && r1 == 0 && r2 == 0 && rd == 0 && !m_drain[k] && s_uready[k][u]) begin
          checks++; if (o_ready[k] !== 1'b1) begin errors++; $display("FAIL rnd_x0_stall k=%0d cyc=%0d got %b expected 1", k, cyc, o_ready[k]); end
        end
        checks++; if (o_pempty[k] !== (!m_drain[k] && m_pend[k] == 0)) begin errors++; $display("FAIL rnd_pempty k=%0d cyc=%0d got %b expected %b", k, cyc, o_pempty[k], (!m_drain[k] && m_pend[k] == 0)); end
        checks++; if (o_stall[k] !== 32'(m_stall[k])) begin errors++; $display("FAIL rnd_stall k=%0d cyc=%0d got %0d expected %0d", k, cyc, o_stall[k], m_stall[k]); end

        nb       = nb_of(k);
        clr_mask = '0;
        for (int uu = 0; uu < nb; uu++) begin
          if (s_uwr[k][uu]) clr_mask[s_uaddr[k][5*uu +: 5]] = 1'b1;
        end
        if (m_drain[k]) begin
          if (m_pend[k] == 0) m_drain[k] = 1'b0;
        end else if (v && f) begin
          m_drain[k] = 1'b1;
        end
        m_pend[k] = m_pend[k] & ~clr_mask;
        if (v && exp_ready && !f && rd != 0) begin
          m_pend[k][rd]  = 1'b1;
          m_owner[k][rd] = u;
        end
        sat = (cw_of(k) == 32) ? 64'hFFFF_FFFF : ((64'd1 << cw_of(k)) - 1);
        if (v && !exp_ready && m_stall[k] < sat) m_stall[k]++;
      end
      tick();
    end
    idle_all();
  endtask

  initial begin
    areset = 1'b1;
    idle_all();
    tick();
    test_reset();
    test_raw();
    test_waw();
    test_same_cycle();
    test_fence();
    test_reset_drain();
    test_out_of_range();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
